// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesting control units (master) and the shared-register arbiter (slave).
// fsm_state mirrors the arbiter FSM (0 = IDLE, 1 = GRANT) so checkers can observe it.
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [IW-1:0]         owner;
  logic                  busy;
  logic                  fsm_state;

  modport master (
    output req, wdata,
    input  gnt, ack, q, owner, busy, fsm_state
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, q, owner, busy, fsm_state
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning a single WIDTH-bit register shared by NREQ requesters.
// Handshake: a requester holds req[i] and its wdata slice stable until it sees ack[i] for one cycle;
// dropping req[i] while granted aborts the write without touching q, owner or the priority pointer.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_reg_arbiter_if.slave   bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e           state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_q;
  logic [IW-1:0]    owner_q;
  logic [NREQ-1:0]  gnt_q;
  logic [NREQ-1:0]  ack_q;
  logic [WIDTH-1:0] q_q;
  logic             busy_q;

  logic [IW-1:0]    win_d;
  logic [IW-1:0]    cand;

  // Walk offsets from farthest to nearest so the set bit closest to ptr wins.
  always_comb begin
    win_d = ptr_q;
    cand  = ptr_q;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr_q + IW'(i);
      if (bus.req[cand]) win_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (|bus.req) begin
            gnt_q   <= ONE << win_d;
            win_q   <= win_d;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end else begin
            gnt_q <= '0;
          end
        end
        GRANT: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (bus.req[win_q]) begin
            q_q     <= bus.wdata[int'(win_q)*WIDTH +: WIDTH];
            ack_q   <= ONE << win_q;
            owner_q <= win_q;
            ptr_q   <= win_q + IW'(1);
          end else begin
            ack_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.q         = q_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios then randomized traffic, all checked
// every cycle against a transaction-level reference model and a write-stream scoreboard.
module tb_shared_reg_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_r;
  logic [NREQ*WIDTH-1:0] wdata_r;

  shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();
  assign bus.req   = req_r;
  assign bus.wdata = wdata_r;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // reference model: arbitration expressed as integer index arithmetic
  int               m_ptr;
  int               m_w;
  int               m_owner;
  bit               m_granted;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  e_gnt;
  logic [NREQ-1:0]  e_ack;
  logic             e_busy;

  // scoreboard: completed writes as {owner, data}
  logic [IW+WIDTH-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ack_order[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int pick_winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_granted = 0; m_ptr = 0; m_owner = 0; m_q = '0;
      e_gnt = '0; e_ack = '0; e_busy = 1'b0;
    end else if (!m_granted) begin
      e_ack = '0;
      w = pick_winner(req_r, m_ptr);
      if (w >= 0) begin
        m_granted = 1; m_w = w;
        e_gnt = NREQ'(1 << w); e_busy = 1'b1;
      end else begin
        e_gnt = '0;
      end
    end else begin
      m_granted = 0; e_gnt = '0; e_busy = 1'b0;
      if (req_r[m_w]) begin
        m_q     = wdata_r[m_w*WIDTH +: WIDTH];
        m_owner = m_w;
        m_ptr   = (m_w + 1) % NREQ;
        e_ack   = NREQ'(1 << m_w);
        exp_q.push_back({IW'(m_w), m_q});
      end else begin
        e_ack = '0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [IW+WIDTH-1:0] item;
    check("gnt",   32'(bus.gnt),   32'(e_gnt));
    check("ack",   32'(bus.ack),   32'(e_ack));
    check("q",     32'(bus.q),     32'(m_q));
    check("owner", 32'(bus.owner), 32'(m_owner));
    check("busy",  32'(bus.busy),  32'(e_busy));
    if (bus.ack != '0) begin
      check("ack_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        item = exp_q.pop_front();
        check("wr_stream", 32'({bus.owner, bus.q}), 32'(item));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  function automatic int ack_index(input logic [NREQ-1:0] a);
    for (int i = 0; i < NREQ; i++) if (a[i]) return i;
    return -1;
  endfunction

  bit acked_prev[NREQ];

  initial begin
    reset   = 1'b1;
    req_r   = 4'b1111;
    wdata_r = 32'hDEADBEEF;

    // reset holds outputs at zero even with every requester active
    repeat (3) step();
    check("rst_q",    32'(bus.q),    32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // single request
    reset = 1'b0;
    req_r = '0;
    step();
    req_r = 4'b0100;
    wdata_r[2*WIDTH +: WIDTH] = 8'hA5;
    step();
    check("single_gnt", 32'(bus.gnt), 32'h4);
    step();
    check("single_q",     32'(bus.q),     32'hA5);
    check("single_ack",   32'(bus.ack),   32'h4);
    check("single_owner", 32'(bus.owner), 32'd2);
    req_r = '0;
    step();
    check("single_ack_drop", 32'(bus.ack), 32'h0);

    // pointer now at 3: requester 0 beats requester 2 by wrapping
    req_r = 4'b0101;
    wdata_r = 32'h44_33_22_11;
    step();
    check("rot_gnt", 32'(bus.gnt), 32'h1);
    step();
    req_r = '0;
    step();

    // round-robin from a fresh pointer with continuous requests
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_r = 4'b1111;
    wdata_r = 32'hC4_B3_A2_91;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.ack != '0) ack_order.push_back(ack_index(bus.ack));
    end
    check("rr_count", 32'(ack_order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ack_order.size()) check("rr_order", 32'(ack_order[i]), 32'(i % NREQ));
    req_r = '0;
    step();
    step();

    // abort: grant requester 1 then withdraw; pointer must stay at 1
    req_r = 4'b0010;
    step();
    check("abort_gnt", 32'(bus.gnt), 32'h2);
    req_r = '0;
    step();
    check("abort_ack",   32'(bus.ack),   32'h0);
    check("abort_q",     32'(bus.q),     32'h91);
    check("abort_owner", 32'(bus.owner), 32'd0);
    req_r = 4'b1111;
    step();
    check("abort_ptr_gnt", 32'(bus.gnt), 32'h2);
    step();
    req_r = '0;
    step();

    // reset while requester 3 is granted: the write is lost
    req_r = 4'b1000;
    wdata_r[3*WIDTH +: WIDTH] = 8'h3C;
    step();
    check("midrst_gnt", 32'(bus.gnt), 32'h8);
    reset = 1'b1;
    step();
    check("midrst_q",   32'(bus.q),   32'h0);
    check("midrst_ack", 32'(bus.ack), 32'h0);
    reset = 1'b0;
    req_r = '0;
    step();

    // randomized traffic
    for (int i = 0; i < NREQ; i++) acked_prev[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acked_prev[i]) begin
          if ($urandom_range(1, 0) == 0) req_r[i] = 1'b0;
          else wdata_r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (req_r[i]) begin
          if ($urandom_range(15, 0) == 0) req_r[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req_r[i] = 1'b1;
          wdata_r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      reset = ($urandom_range(99, 0) == 0);
      step();
      for (int i = 0; i < NREQ; i++) acked_prev[i] = bus.ack[i];
    end

    reset = 1'b0;
    req_r = '0;
    repeat (3) step();
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one WIDTH-bit register, a bank of synchronously reset D flip-flops, among NREQ requesters. Each requester raises a request with its write data; the arbiter grants one requester at a time, commits that requester's data into the shared register and acknowledges it. The block sits between the requesting control units and the shared flip-flop register, and is the only writer of that register.

## Interface

- NREQ, 4, number of requesters; power of two, 2..16
- WIDTH, 8, shared register width in bits
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk
- req  input  NREQ  request per requester; bit i = requester i
- wdata  input  NREQ*WIDTH  write data; requester i at bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- ack  output  NREQ  one-hot, one-cycle write-done pulse, registered
- q  output  WIDTH  shared register contents
- owner  output  log2(NREQ)  index of last requester that completed a write
- busy  output  1  high while in GRANT state

## Operation

- Reset (reset=1 at an edge): state=IDLE, q=0, gnt=0, ack=0, owner=0, busy=0, priority pointer ptr=0. Reset overrides every other event, including a write in progress.
- FSM states: IDLE, GRANT.
- IDLE: ack is cleared each cycle unless being set. If req != 0, pick the winner as the first set bit of req searching ptr, ptr+1, ..., wrapping modulo NREQ. At the edge, gnt <= onehot(winner), busy <= 1, state <= GRANT. If req == 0, stay in IDLE with gnt=0.
- GRANT, requester w granted, at the next edge:
  - If req[w]=1: q <= wdata[w], ack <= onehot(w), owner <= w, ptr <= (w+1) mod NREQ, gnt <= 0, busy <= 0, state <= IDLE.
  - If req[w]=0 (abort): q, owner and ptr are unchanged, ack stays 0, gnt <= 0, busy <= 0, state <= IDLE.
- Requests and data from non-granted requesters are ignored in GRANT.
- The requester must hold req and wdata stable from the assertion of req until it sees ack.
- A requester that keeps req high during its ack cycle is re-arbitrated in that IDLE cycle. Because ptr has advanced, the other pending requesters are served first.
- The pointer wraps from NREQ-1 to 0.
- At most one bit of gnt is set and at most one bit of ack is set; gnt and ack are never high in the same cycle.

## Timing

- req sampled high in IDLE at edge k gives gnt and busy high after edge k.
- The write happens at edge k+1: q takes the new value, ack is high and gnt is low for the cycle after k+1.
- Latency from a sampled request to updated q is 2 edges.
- Peak throughput is one write per 2 cycles. With continuous requests, IDLE and GRANT alternate.
- ack is high for exactly one cycle per completed write.
- All outputs are direct register outputs, with no combinational path from inputs to outputs.
- If reset is asserted during GRANT, no write occurs at that edge. All outputs take their reset values after that edge.

## Test plan

- Reset: drive reset=1 with req=4'b1111 and arbitrary wdata -> after the edge q=0, gnt=0, ack=0, owner=0, busy=0. These values hold for as long as reset is high.
- Single request: req=4'b0100, wdata[2]=8'hA5 -> gnt=4'b0100 one edge later. q=8'hA5, ack=4'b0100, owner=2 after the next edge. ack drops after 1 cycle.
- Round-robin with wrap: hold req=4'b1111 with distinct data per requester -> ack order 0,1,2,3,0 on every second cycle. q tracks each winner's data and owner goes 0,1,2,3,0.
- Pointer rotation: after requester 2 has been served, req=4'b0101 -> requester 0 wins, because the search starts at 3 and wraps to 0.
- Abort: grant requester 1, then drop req[1] during GRANT -> no ack, q and owner unchanged. The next arbitration still starts at the old ptr.
- Reset mid-operation: assert reset while gnt=4'b1000 with wdata[3]=8'h3C -> q stays 0, no ack, and all outputs take their reset values after the edge.
